// File: rtl/trap_controller.sv
// trap_controller: M-mode trap entry and mret sequencer for the CSR file.
// Build option: TRAP_CTRL_VECTORED_EN enables vectored interrupt entry.
module trap_controller #(
  parameter int XLEN          = 64,
  parameter int VECTOR_STRIDE = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            exception_valid_i,
  input  logic [4:0]      exception_cause_i,
  input  logic [XLEN-1:0] exception_pc_i,
  input  logic [XLEN-1:0] exception_tval_i,
  input  logic            mret_valid_i,
  input  logic [XLEN-1:0] interrupt_pc_i,
  input  logic            irq_meip_i,
  input  logic            irq_mtip_i,
  input  logic            irq_msip_i,
  input  logic            mie_meie_i,
  input  logic            mie_mtie_i,
  input  logic            mie_msie_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-3:0] mtvec_base_i,
  input  logic [1:0]      mtvec_mode_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            req_ready_o,
  output logic            trap_csr_we_o,
  output logic [11:0]     trap_csr_address_o,
  output logic [XLEN-1:0] trap_csr_data_o,
  input  logic            trap_csr_ack_i,
  output logic            mstatus_trap_o,
  output logic            mstatus_mret_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            busy_o
);

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    REDIRECT
  } state_t;

  state_t state_q, state_d;

  logic            irq_q;
  logic            mret_q;
  logic [4:0]      cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] target_q;

  logic            irq_mei, irq_msi, irq_mti;
  logic            irq_take;
  logic [4:0]      irq_code;
  logic            acc_exc, acc_mret, acc_irq;
  logic [XLEN-1:0] base_addr;
  logic [XLEN-1:0] irq_tgt;

  assign irq_mei  = irq_meip_i & mie_meie_i;
  assign irq_msi  = irq_msip_i & mie_msie_i;
  assign irq_mti  = irq_mtip_i & mie_mtie_i;
  assign irq_take = mstatus_mie_i & (irq_mei | irq_msi | irq_mti);

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    irq_code = 5'd7;
    if (irq_mei)      irq_code = 5'd11;
    else if (irq_msi) irq_code = 5'd3;
  end

  assign acc_exc  = (state_q == IDLE) & exception_valid_i;
  assign acc_mret = (state_q == IDLE) & ~exception_valid_i
                  & mret_valid_i;
  assign acc_irq  = (state_q == IDLE) & ~exception_valid_i
                  & ~mret_valid_i & irq_take;

  assign base_addr = {mtvec_base_i, 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  logic [XLEN-1:0] vec_off;
  assign vec_off = XLEN'(VECTOR_STRIDE) * XLEN'(irq_code);
  assign irq_tgt = (mtvec_mode_i == 2'd1) ? base_addr + vec_off
                                          : base_addr;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_mode_i;
  assign irq_tgt     = base_addr;
`endif

  // State register and request latch; mret target sampled late.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      mret_q   <= 1'b0;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc_exc) begin
        irq_q    <= 1'b0;
        mret_q   <= 1'b0;
        cause_q  <= exception_cause_i;
        pc_q     <= exception_pc_i;
        tval_q   <= exception_tval_i;
        target_q <= base_addr;
      end else if (acc_mret) begin
        irq_q    <= 1'b0;
        mret_q   <= 1'b1;
      end else if (acc_irq) begin
        irq_q    <= 1'b1;
        mret_q   <= 1'b0;
        cause_q  <= irq_code;
        pc_q     <= interrupt_pc_i;
        tval_q   <= '0;
        target_q <= irq_tgt;
      end
      if (state_q == WR_MSTATUS && mret_q) begin
        target_q <= mepc_i;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d            = state_q;
    req_ready_o        = 1'b0;
    trap_csr_we_o      = 1'b0;
    trap_csr_address_o = '0;
    trap_csr_data_o    = '0;
    mstatus_trap_o     = 1'b0;
    mstatus_mret_o     = 1'b0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (exception_valid_i)  state_d = WR_MEPC;
        else if (mret_valid_i)  state_d = WR_MSTATUS;
        else if (irq_take)      state_d = WR_MEPC;
      end
      WR_MEPC: begin
        trap_csr_we_o      = 1'b1;
        trap_csr_address_o = CSR_MEPC;
        trap_csr_data_o    = pc_q;
        if (trap_csr_ack_i) state_d = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        trap_csr_we_o      = 1'b1;
        trap_csr_address_o = CSR_MCAUSE;
        trap_csr_data_o    = {irq_q, {(XLEN-6){1'b0}}, cause_q};
        if (trap_csr_ack_i) state_d = WR_MTVAL;
      end
      WR_MTVAL: begin
        trap_csr_we_o      = 1'b1;
        trap_csr_address_o = CSR_MTVAL;
        trap_csr_data_o    = tval_q;
        if (trap_csr_ack_i) state_d = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        mstatus_trap_o = ~mret_q;
        mstatus_mret_o = mret_q;
        state_d        = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: transaction scoreboard plus directed scenarios
// and a randomized phase for trap_controller.
module tb_trap_controller;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        exception_valid_i = 1'b0;
  logic [4:0]  exception_cause_i = '0;
  logic [63:0] exception_pc_i = '0;
  logic [63:0] exception_tval_i = '0;
  logic        mret_valid_i = 1'b0;
  logic [63:0] interrupt_pc_i = '0;
  logic        irq_meip_i = 1'b0;
  logic        irq_mtip_i = 1'b0;
  logic        irq_msip_i = 1'b0;
  logic        mie_meie_i = 1'b0;
  logic        mie_mtie_i = 1'b0;
  logic        mie_msie_i = 1'b0;
  logic        mstatus_mie_i = 1'b0;
  logic [61:0] mtvec_base_i = '0;
  logic [1:0]  mtvec_mode_i = '0;
  logic [63:0] mepc_i = '0;
  logic        req_ready_o;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_address_o;
  logic [63:0] trap_csr_data_o;
  logic        trap_csr_ack_i = 1'b1;
  logic        mstatus_trap_o;
  logic        mstatus_mret_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i = 1'b1;
  logic        busy_o;

  trap_controller #(.XLEN(64), .VECTOR_STRIDE(4)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .exception_valid_i(exception_valid_i),
    .exception_cause_i(exception_cause_i),
    .exception_pc_i(exception_pc_i),
    .exception_tval_i(exception_tval_i),
    .mret_valid_i(mret_valid_i),
    .interrupt_pc_i(interrupt_pc_i),
    .irq_meip_i(irq_meip_i), .irq_mtip_i(irq_mtip_i),
    .irq_msip_i(irq_msip_i),
    .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i),
    .mie_msie_i(mie_msie_i),
    .mstatus_mie_i(mstatus_mie_i),
    .mtvec_base_i(mtvec_base_i), .mtvec_mode_i(mtvec_mode_i),
    .mepc_i(mepc_i),
    .req_ready_o(req_ready_o),
    .trap_csr_we_o(trap_csr_we_o),
    .trap_csr_address_o(trap_csr_address_o),
    .trap_csr_data_o(trap_csr_data_o),
    .trap_csr_ack_i(trap_csr_ack_i),
    .mstatus_trap_o(mstatus_trap_o),
    .mstatus_mret_o(mstatus_mret_o),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i),
    .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Expected event list for the transaction in flight.
  localparam int K_WR  = 0;
  localparam int K_PT  = 1;
  localparam int K_PM  = 2;
  localparam int K_RD  = 3;
  localparam int K_RDM = 4;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  logic        mon_on = 1'b0;
  logic        acc_exc = 1'b0;
  logic        acc_mret = 1'b0;
  logic [63:0] mret_pc;

  function automatic ev_t mk(input int k, input logic [11:0] a,
                             input logic [63:0] d);
    ev_t r;
    r.kind = k;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  task automatic push_trap(input logic intr, input logic [4:0] code,
                           input logic [63:0] epc,
                           input logic [63:0] tval);
    logic [63:0] tgt;
    logic [63:0] mc;
    tgt = {mtvec_base_i, 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    if (intr && mtvec_mode_i == 2'd1) tgt = tgt + 64'(4 * code);
`endif
    mc = {60'd0, 4'd0} + 64'(code);
    if (intr) mc = mc + 64'h8000_0000_0000_0000;
    q.push_back(mk(K_WR, 12'h341, epc));
    q.push_back(mk(K_WR, 12'h342, mc));
    q.push_back(mk(K_WR, 12'h343, tval));
    q.push_back(mk(K_PT, 12'h0, 64'd0));
    q.push_back(mk(K_RD, 12'h0, tgt));
  endtask

  // Scoreboard: compares DUT outputs against the event list.
  always @(negedge clock_i) begin
    logic [2:0] pe;
    acc_exc  = 1'b0;
    acc_mret = 1'b0;
    if (mon_on) begin
      if (q.size() == 0) begin
        chk("idle_busy", busy_o, 0);
        chk("idle_ready", req_ready_o, 1);
        chk("idle_we", trap_csr_we_o, 0);
        chk("idle_ptrap", mstatus_trap_o, 0);
        chk("idle_pmret", mstatus_mret_o, 0);
        chk("idle_rvalid", redirect_valid_o, 0);
        pe = {irq_meip_i & mie_meie_i,
              irq_msip_i & mie_msie_i,
              irq_mtip_i & mie_mtie_i};
        if (!reset_i) begin
          if (exception_valid_i) begin
            acc_exc = 1'b1;
            push_trap(1'b0, exception_cause_i,
                      exception_pc_i, exception_tval_i);
          end else if (mret_valid_i) begin
            acc_mret = 1'b1;
            q.push_back(mk(K_PM, 12'h0, 64'd0));
            q.push_back(mk(K_RDM, 12'h0, 64'd0));
          end else if (mstatus_mie_i && pe != 3'b000) begin
            push_trap(1'b1, pe[2] ? 5'd11 : pe[1] ? 5'd3 : 5'd7,
                      interrupt_pc_i, 64'd0);
          end
        end
      end else begin
        e = q[0];
        chk("busy", busy_o, 1);
        chk("ready_busy", req_ready_o, 0);
        if (e.kind == K_WR) begin
          chk("wr_we", trap_csr_we_o, 1);
          chk("wr_addr", 64'(trap_csr_address_o), 64'(e.addr));
          chk("wr_data", trap_csr_data_o, e.data);
          chk("wr_pulse", {mstatus_trap_o, mstatus_mret_o}, 0);
          chk("wr_rvalid", redirect_valid_o, 0);
          if (trap_csr_ack_i) void'(q.pop_front());
        end else if (e.kind == K_PT || e.kind == K_PM) begin
          chk("ms_trap", mstatus_trap_o, 64'(e.kind == K_PT));
          chk("ms_mret", mstatus_mret_o, 64'(e.kind == K_PM));
          chk("ms_we", trap_csr_we_o, 0);
          chk("ms_rvalid", redirect_valid_o, 0);
          if (e.kind == K_PM) mret_pc = mepc_i;
          void'(q.pop_front());
        end else begin
          chk("rd_valid", redirect_valid_o, 1);
          chk("rd_pc", redirect_pc_o,
              e.kind == K_RDM ? mret_pc : e.data);
          chk("rd_we", trap_csr_we_o, 0);
          chk("rd_pulse", {mstatus_trap_o, mstatus_mret_o}, 0);
          if (redirect_ready_i) void'(q.pop_front());
        end
      end
      if (reset_i) q.delete();
    end
  end

  task automatic nxt();
    @(posedge clock_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock_i);
    at_neg();
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_we", trap_csr_we_o, 0);
    chk("rst_addr", 64'(trap_csr_address_o), 0);
    chk("rst_data", trap_csr_data_o, 0);
    chk("rst_pulse", {mstatus_trap_o, mstatus_mret_o}, 0);
    chk("rst_rvalid", redirect_valid_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    nxt();
    reset_i = 1'b0;
    mon_on  = 1'b1;

    // 1: exception with ack/ready tied high.
    mtvec_base_i      = 62'h2000_0000;
    exception_cause_i = 5'd2;
    exception_pc_i    = 64'h8000_0100;
    exception_tval_i  = 64'h13;
    exception_valid_i = 1'b1;
    at_neg(); chk("t1_c0_ready", req_ready_o, 1);
    nxt(); exception_valid_i = 1'b0;
    at_neg(); chk("t1_c1_addr", 64'(trap_csr_address_o), 64'h341);
    chk("t1_c1_data", trap_csr_data_o, 64'h8000_0100);
    nxt(); at_neg();
    chk("t1_c2_addr", 64'(trap_csr_address_o), 64'h342);
    chk("t1_c2_data", trap_csr_data_o, 64'd2);
    nxt(); at_neg();
    chk("t1_c3_data", trap_csr_data_o, 64'h13);
    nxt(); at_neg(); chk("t1_c4_trap", mstatus_trap_o, 1);
    nxt(); at_neg(); chk("t1_c5_rv", redirect_valid_o, 1);
    chk("t1_c5_pc", redirect_pc_o, 64'h8000_0000);
    nxt(); at_neg(); chk("t1_c6_busy", busy_o, 0);

    // 2: MEI and MTI pending, vectored mode.
    mtvec_base_i   = 62'h400;
    mtvec_mode_i   = 2'd1;
    interrupt_pc_i = 64'h1234;
    irq_meip_i = 1'b1; irq_mtip_i = 1'b1;
    mie_meie_i = 1'b1; mie_mtie_i = 1'b1;
    mstatus_mie_i = 1'b1;
    nxt();
    irq_meip_i = 1'b0; irq_mtip_i = 1'b0; mstatus_mie_i = 1'b0;
    at_neg(); chk("t2_mepc", trap_csr_data_o, 64'h1234);
    nxt(); at_neg();
    chk("t2_mcause", trap_csr_data_o, 64'h8000_0000_0000_000B);
    nxt(); at_neg(); chk("t2_mtval", trap_csr_data_o, 64'd0);
    nxt(); nxt(); at_neg();
`ifdef TRAP_CTRL_VECTORED_EN
    chk("t2_pc", redirect_pc_o, 64'h102C);
`else
    chk("t2_pc", redirect_pc_o, 64'h1000);
`endif
    nxt();

    // 3: exception and mret together; exception wins.
    mtvec_base_i      = 62'h40;
    mtvec_mode_i      = 2'd0;
    mepc_i            = 64'hABC0;
    exception_cause_i = 5'd5;
    exception_pc_i    = 64'h100;
    exception_tval_i  = 64'd0;
    exception_valid_i = 1'b1;
    mret_valid_i      = 1'b1;
    nxt(); exception_valid_i = 1'b0;
    at_neg(); chk("t3_first_mepc", trap_csr_data_o, 64'h100);
    repeat (4) nxt();
    at_neg(); chk("t3_trap_pc", redirect_pc_o, 64'h100);
    nxt(); at_neg(); chk("t3_idle_ready", req_ready_o, 1);
    nxt(); mret_valid_i = 1'b0;
    at_neg(); chk("t3_mret_pulse", mstatus_mret_o, 1);
    nxt(); at_neg(); chk("t3_mret_pc", redirect_pc_o, 64'hABC0);
    nxt(); at_neg(); chk("t3_done", busy_o, 0);

    // 4: ack withheld three cycles in WR_MCAUSE.
    exception_cause_i = 5'd4;
    exception_pc_i    = 64'h200;
    exception_valid_i = 1'b1;
    nxt(); exception_valid_i = 1'b0;
    nxt(); trap_csr_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4_hold_addr", 64'(trap_csr_address_o), 64'h342);
      chk("t4_hold_data", trap_csr_data_o, 64'd4);
      nxt();
    end
    trap_csr_ack_i = 1'b1;
    nxt(); nxt(); nxt();
    at_neg(); chk("t4_late_rv", redirect_valid_o, 1);
    nxt();

    // 5: timer pending but globally masked, then unmasked.
    irq_mtip_i = 1'b1; mie_mtie_i = 1'b1; mie_meie_i = 1'b0;
    repeat (3) begin
      at_neg(); chk("t5_masked", busy_o, 0);
      nxt();
    end
    mstatus_mie_i = 1'b1;
    nxt();
    irq_mtip_i = 1'b0; mstatus_mie_i = 1'b0;
    nxt(); at_neg();
    chk("t5_mcause", trap_csr_data_o, 64'h8000_0000_0000_0007);
    repeat (5) nxt();

    // 6: reset while in WR_MTVAL.
    exception_valid_i = 1'b1;
    nxt(); exception_valid_i = 1'b0;
    nxt(); nxt(); reset_i = 1'b1;
    at_neg(); chk("t6_mtval", 64'(trap_csr_address_o), 64'h343);
    nxt(); reset_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t6_busy", busy_o, 0);
      chk("t6_trap", mstatus_trap_o, 0);
      chk("t6_rv", redirect_valid_o, 0);
      nxt();
    end

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      nxt();
      if (acc_exc) exception_valid_i = 1'b0;
      if (acc_mret) mret_valid_i = 1'b0;
      if (!exception_valid_i && $urandom_range(0, 9) == 0) begin
        exception_valid_i = 1'b1;
        exception_cause_i = 5'($urandom);
        exception_pc_i    = {$urandom, $urandom};
        exception_tval_i  = {$urandom, $urandom};
      end
      if (!mret_valid_i && $urandom_range(0, 11) == 0)
        mret_valid_i = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        {irq_meip_i, irq_mtip_i, irq_msip_i} = 3'($urandom);
        {mie_meie_i, mie_mtie_i, mie_msie_i} = 3'($urandom);
        mstatus_mie_i = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 3) == 0) mepc_i = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) begin
        mtvec_base_i = {$urandom, $urandom};
        mtvec_mode_i = 2'($urandom);
        interrupt_pc_i = {$urandom, $urandom};
      end
      trap_csr_ack_i   = ($urandom_range(0, 3) != 0);
      redirect_ready_i = ($urandom_range(0, 3) != 0);
    end

    nxt();
    exception_valid_i = 1'b0;
    mret_valid_i      = 1'b0;
    mstatus_mie_i     = 1'b0;
    trap_csr_ack_i    = 1'b1;
    redirect_ready_i  = 1'b1;
    for (int i = 0; i < 40 && (busy_o || q.size() != 0); i++) nxt();
    at_neg();
    chk("drain_busy", busy_o, 0);
    chk("drain_queue", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
